// File: rtl/regfile_wb_if.sv
// Write-request and read-port bundle between the execute/write-back stage and the register file.
interface regfile_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;

    modport master (
        output wr_valid, wr_addr, wr_data, rs1, rs2,
        input  wr_ready, rs1_data, rs2_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rs1, rs2,
        output wr_ready, rs1_data, rs2_data
    );
endinterface

// File: rtl/regfile_wb_writer.sv
// Integer register file write-back path: hardware clear after reset, one-deep
// pending write stage, and two combinational read ports with bypass of that stage.
//
// state  | meaning
// S_INIT | clearing mem one entry per edge, writes refused
// S_RUN  | accepting writes, reads valid
module regfile_wb_writer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    regfile_wb_if.slave      bus,
    output logic             init_done,
    output logic [CNT_W-1:0] wr_count
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] init_ptr;

    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;

    logic              ready;
    logic              done;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              accept;
    logic              accept_nz;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_INIT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = pend_addr;
        mem_wdata  = pend_data;
        case (state)
            S_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = init_ptr;
                mem_wdata = '0;
                if (init_ptr == LAST_IDX) state_next = S_RUN;
            end
            S_RUN: begin
                ready  = 1'b1;
                done   = 1'b1;
                mem_we = pend_valid;
            end
            default: state_next = S_INIT;
        endcase
    end

    assign bus.wr_ready = ready;
    assign init_done    = done;
    assign accept       = bus.wr_valid & ready;
    // Writes to index 0 complete the handshake but never reach the pending stage.
    assign accept_nz    = accept & (bus.wr_addr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 init_ptr <= '0;
        else if (state == S_INIT) init_ptr <= init_ptr + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
        end else begin
            pend_valid <= accept_nz;
            if (accept_nz) begin
                pend_addr <= bus.wr_addr;
                pend_data <= bus.wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             wr_count <= '0;
        else if (pend_valid) wr_count <= wr_count + 1'b1;
    end

    // Array has no reset; the INIT sweep is what clears it.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_comb begin
        if (!done || bus.rs1 == '0)
            bus.rs1_data = '0;
        else if (pend_valid && pend_addr == bus.rs1)
            bus.rs1_data = pend_data;
        else
            bus.rs1_data = mem[bus.rs1];
    end

    always_comb begin
        if (!done || bus.rs2 == '0)
            bus.rs2_data = '0;
        else if (pend_valid && pend_addr == bus.rs2)
            bus.rs2_data = pend_data;
        else
            bus.rs2_data = mem[bus.rs2];
    end
endmodule

// File: tb/tb_regfile_wb_writer.sv
// Randomized bench for regfile_wb_writer against an architectural register model
// where every accepted write is visible immediately and commits count one edge later.
module tb_regfile_wb_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_done;
    logic [15:0] wr_count;

    regfile_wb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_wb_writer #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .init_done (init_done),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] arch [32];
    int          init_left;
    bit          ref_pend;
    int unsigned ref_count;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [4:0] idx);
        if (init_left != 0 || idx == 5'd0) return 32'd0;
        return arch[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) arch[i] = 32'd0;
        init_left = 32;
        ref_pend  = 1'b0;
        ref_count = 0;
    endtask

    task automatic step(input bit v, input logic [4:0] a, input logic [31:0] d);
        bit rdy;
        bus.wr_valid = v;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        rdy = (init_left == 0);
        @(posedge clk);
        #1;
        if (ref_pend) ref_count++;
        ref_pend = rdy && v && (a != 5'd0);
        if (ref_pend) arch[a] = d;
        if (init_left > 0) init_left--;
        bus.wr_valid = 1'b0;
        check_val("wr_ready", {31'd0, bus.wr_ready}, {31'd0, init_left == 0});
        check_val("init_done", {31'd0, init_done}, {31'd0, init_left == 0});
        check_val("wr_count", {16'd0, wr_count}, ref_count & 32'hFFFF);
    endtask

    task automatic check_reads(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        bus.rs1 = a1;
        bus.rs2 = a2;
        #1;
        check_val({tag, "_rs1"}, bus.rs1_data, ref_read(a1));
        check_val({tag, "_rs2"}, bus.rs2_data, ref_read(a2));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"}, {31'd0, bus.wr_ready}, 32'd0);
        check_val({tag, "_done"}, {31'd0, init_done}, 32'd0);
        check_val({tag, "_count"}, {16'd0, wr_count}, 32'd0);
        check_val({tag, "_rs1"}, bus.rs1_data, 32'd0);
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rs1      = 5'd5;
        bus.rs2      = 5'd0;
        model_reset();
        #3;
        check_reset_outputs("reset");

        @(posedge clk);
        #1;
        rst = 1'b0;

        // T1: clear sequence, with a write request held that must be ignored
        for (int e = 0; e < 32; e++) begin
            step(1'b1, 5'd9, $urandom);
            check_reads("t1", 5'd5, 5'd9);
        end
        check_reads("t1_end", 5'd5, 5'd9);

        // T2: bypass then committed value
        step(1'b1, 5'd3, 32'hDEADBEEF);
        check_reads("t2_bypass", 5'd3, 5'd0);
        step(1'b0, 5'd0, 32'd0);
        check_reads("t2_commit", 5'd3, 5'd3);

        // T3: index 0 write dropped
        step(1'b1, 5'd0, 32'hFFFFFFFF);
        check_reads("t3", 5'd3, 5'd0);
        step(1'b0, 5'd0, 32'd0);
        check_reads("t3_idle", 5'd0, 5'd0);

        // T4: back-to-back to same index
        step(1'b1, 5'd7, 32'd1);
        check_reads("t4_first", 5'd7, 5'd3);
        step(1'b1, 5'd7, 32'd2);
        check_reads("t4_second", 5'd7, 5'd7);
        step(1'b0, 5'd0, 32'd0);
        step(1'b0, 5'd0, 32'd0);
        check_reads("t4_settled", 5'd7, 5'd7);

        // T5: fill every nonzero index
        for (int i = 1; i < 32; i++) step(1'b1, 5'(i), 32'(i * 3));
        step(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 32; i++) check_reads("t5", 5'(i), 5'(31 - i));

        // Random traffic over a small index set to exercise bypass collisions
        for (int n = 0; n < 300; n++) begin
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom);
            check_reads("rand", 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
        end
        step(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 32; i++) check_reads("rand_all", 5'(i), 5'(i));

        // T6: reset while a write is pending
        step(1'b1, 5'd12, 32'hA5A5_1234);
        bus.rs1 = 5'd12;
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("t6_async");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int e = 0; e < 32; e++) step(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 32; i++) check_reads("t6_cleared", 5'(i), 5'(31 - i));
        step(1'b0, 5'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
